// File: rtl/bcd_serial_add_ctrl.sv
// Serial BCD adder: one digit per two cycles (binary add, then decimal
// correction) through a single time-shared 4-bit adder.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a_bcd,
  input  logic [4*DIGITS-1:0]   b_bcd,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum_bcd,
  output logic                  carry_out,
  output logic                  err
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, ADD, CORR, DONE} state_t;

  state_t             state_q;
  logic [W-1:0]       a_q, b_q, digits_q, sum_q;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q, err_pend_q;
  logic [4:0]         res_q;
  logic               busy_q, done_q, carry_out_q, err_q;

  logic [3:0]         add_x, add_y;
  logic               add_cin;
  logic [4:0]         add_out;
  logic               res_gt9;
  logic [3:0]         corr_digit;
  logic [W-1:0]       digits_d;
  logic               range_err;

  // The one adder: operands are steered by phase (ADD vs CORR).
  assign add_out = {1'b0, add_x} + {1'b0, add_y} + {4'b0000, add_cin};

  assign res_gt9    = (res_q > 5'd9);
  assign corr_digit = res_gt9 ? add_out[3:0] : res_q[3:0];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    add_x   = a_q[4*idx_q +: 4];
    add_y   = b_q[4*idx_q +: 4];
    add_cin = carry_q;
    if (state_q == CORR) begin
      add_x   = res_q[3:0];
      add_y   = 4'b0110;
      add_cin = 1'b0;
    end

    digits_d                  = digits_q;
    digits_d[4*idx_q +: 4]    = corr_digit;

    range_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a_bcd[4*i +: 4] > 4'd9 || b_bcd[4*i +: 4] > 4'd9) range_err = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      digits_q    <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      err_pend_q  <= 1'b0;
      res_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      carry_out_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q        <= a_bcd;
            b_q        <= b_bcd;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            err_pend_q <= range_err;
            busy_q     <= 1'b1;
            state_q    <= ADD;
          end
        end
        ADD: begin
          res_q   <= add_out;
          state_q <= CORR;
        end
        CORR: begin
          digits_q <= digits_d;
          carry_q  <= res_gt9;
          if (idx_q == IDX_W'(DIGITS - 1)) begin
            // Result registers take the just-corrected top digit directly.
            sum_q       <= digits_d;
            carry_out_q <= res_gt9;
            err_q       <= err_pend_q;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= ADD;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum_bcd   = sum_q;
  assign carry_out = carry_out_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl (DIGITS=4): vector table plus
// hand-written restart-ignore and mid-operation reset sequences.
module tb_bcd_serial_add_ctrl;

  localparam int DIGITS = 4;
  localparam int LAT    = 2 * DIGITS + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a_bcd, b_bcd;
  logic        busy, done, carry_out, err;
  logic [15:0] sum_bcd;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a_bcd     (a_bcd),
    .b_bcd     (b_bcd),
    .busy      (busy),
    .done      (done),
    .sum_bcd   (sum_bcd),
    .carry_out (carry_out),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        co;
    logic        err;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one start and observes 20 cycles; optionally pulses start again
  // with other operands in cycle inj (0 = no second pulse).
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] a2, input logic [15:0] b2, input int inj,
                        output int dcyc, output int dcnt, output logic [15:0] s,
                        output logic co, output logic e, output logic busy_ok);
    @(negedge clk);
    a_bcd = a;
    b_bcd = b;
    start = 1'b1;
    dcyc = -1; dcnt = 0; busy_ok = 1'b1; s = '0; co = 1'b0; e = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (busy !== (cyc <= LAT)) busy_ok = 1'b0;
      if (done === 1'b1) begin
        dcnt++;
        if (dcyc < 0) begin
          dcyc = cyc;
          s    = sum_bcd;
          co   = carry_out;
          e    = err;
        end
      end
      start = (cyc == inj);
      if (cyc == inj) begin
        a_bcd = a2;
        b_bcd = b2;
      end
    end
    start = 1'b0;
  endtask

  int          dcyc, dcnt;
  logic [15:0] s;
  logic        co, e, bok;

  initial begin
    vecs[0] = '{16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0};
    vecs[1] = '{16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[3] = '{16'h00A0, 16'h0001, 16'h0101, 1'b0, 1'b1};
    vecs[4] = '{16'h9999, 16'h9999, 16'h9998, 1'b1, 1'b0};
    vecs[5] = '{16'h0500, 16'h0499, 16'h0999, 1'b0, 1'b0};
    vecs[6] = '{16'h4321, 16'h5679, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h000F, 16'h0000, 16'h0015, 1'b0, 1'b1};
    vecs[8] = '{16'h0009, 16'h0001, 16'h0010, 1'b0, 1'b0};

    reset = 1'b1;
    start = 1'b0;
    a_bcd = '0;
    b_bcd = '0;
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_sum", sum_bcd, 0);
    check("reset_co", carry_out, 0);
    check("reset_err", err, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, 16'h0, 16'h0, 0, dcyc, dcnt, s, co, e, bok);
      check($sformatf("v%0d_done_cycle", i), dcyc, LAT);
      check($sformatf("v%0d_done_count", i), dcnt, 1);
      check($sformatf("v%0d_sum", i), s, vecs[i].sum);
      check($sformatf("v%0d_carry", i), co, vecs[i].co);
      check($sformatf("v%0d_err", i), e, vecs[i].err);
      check($sformatf("v%0d_busy_window", i), bok, 1);
      check($sformatf("v%0d_sum_held", i), sum_bcd, vecs[i].sum);
    end

    // Second start during cycle 4 must be ignored.
    run_op(16'h1234, 16'h5678, 16'h9999, 16'h9999, 4, dcyc, dcnt, s, co, e, bok);
    check("restart_done_cycle", dcyc, LAT);
    check("restart_done_count", dcnt, 1);
    check("restart_sum", s, 16'h6912);
    check("restart_carry", co, 0);
    check("restart_busy_window", bok, 1);

    // Reset in cycle 5 of an operation: outputs clear at once, no done follows.
    @(negedge clk);
    a_bcd = 16'h1234;
    b_bcd = 16'h5678;
    start = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_sum", sum_bcd, 0);
    check("midrst_co", carry_out, 0);
    check("midrst_err", err, 0);
    @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dcnt++;
    end
    check("midrst_no_activity", dcnt, 0);

    run_op(16'h0005, 16'h0005, 16'h0, 16'h0, 0, dcyc, dcnt, s, co, e, bok);
    check("post_rst_done_cycle", dcyc, LAT);
    check("post_rst_sum", s, 16'h0010);
    check("post_rst_carry", co, 0);
    check("post_rst_err", e, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
